fir_decimator: RTL and testbench

//  Downstream stage of myfir: takes the filtered sample stream (DOUT/VOUT) and decimates it by 2**DEC_LOG2.

---
 rtl/fir_dec_pkg.sv | 9 +
 rtl/fir_dec_if.sv | 15 +
 rtl/fir_dec_fifo.sv | 38 +++
 rtl/fir_decimator.sv | 74 +++++++
 tb/tb_fir_decimator.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/fir_dec_pkg.sv
// fir_dec_pkg: shared defaults and sample/accumulator/exponent types for the FIR decimator.
package fir_dec_pkg;
  localparam int DEF_DATA_WIDTH = 13;
  localparam int DEF_LOG2_MAX = 4;
  localparam int DEF_FIFO_DEPTH = 8;
  typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;
  typedef logic signed [DEF_DATA_WIDTH+DEF_LOG2_MAX-1:0] acc_t;
  typedef logic [$clog2(DEF_LOG2_MAX+1)-1:0] dec_t;
endpackage

// File: rtl/fir_dec_if.sv
// fir_dec_if: sample-in / decimated-out bundle of the FIR decimator.
//  master (source/sink side): drives DIN, VIN, EN, DEC_LOG2, READY, CLR_OVF; observes DOUT, VOUT, COUNT, OVF.
//  slave (decimator side): the reverse.
interface fir_dec_if import fir_dec_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_MAX = DEF_LOG2_MAX,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  logic signed [DATA_WIDTH-1:0] DIN, DOUT;
  logic VIN, EN, READY, VOUT, OVF, CLR_OVF;
  logic [$clog2(LOG2_MAX+1)-1:0] DEC_LOG2;
  logic [$clog2(FIFO_DEPTH):0] COUNT;
  modport master(output DIN, VIN, EN, DEC_LOG2, READY, CLR_OVF, input DOUT, VOUT, COUNT, OVF);
  modport slave(input DIN, VIN, EN, DEC_LOG2, READY, CLR_OVF, output DOUT, VOUT, COUNT, OVF);
endinterface

// File: rtl/fir_dec_fifo.sv
// fir_dec_fifo: synchronous show-ahead FIFO; head_o is the oldest entry (0 when empty).
//  clk/rst: clock, async active-high reset. wr_i/din_i: push. rd_i: pop.
//  full_o, empty_o, count_o: occupancy. head_o: show-ahead data.
module fir_dec_fifo import fir_dec_pkg::*; #(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter type T = sample_t
)(
  input  logic clk,
  input  logic rst,
  input  logic wr_i,
  input  logic rd_i,
  input  T din_i,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output T head_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_i) wp_q <= wp_q + 1'b1;
      if (rd_i) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr_i) - (AW+1)'(rd_i);
    end
  always_ff @(posedge clk)
    if (wr_i) mem_q[wp_q] <= din_i;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o = empty_o ? T'(0) : mem_q[rp_q];
endmodule

// File: rtl/fir_decimator.sv
// fir_decimator: decimates the myfir sample stream by 2**DEC_LOG2 into a show-ahead FIFO with overflow flag.
//  CLK/RST: clock, async active-high reset. bus (fir_dec_if.slave): DIN/VIN in, EN, DEC_LOG2,
//  DOUT/VOUT/READY out handshake, COUNT occupancy, OVF sticky drop flag, CLR_OVF clear.
//  FIR_DEC_AVG_EN defined: integrate-and-dump (group average); undefined: keep first sample of each group.
module fir_decimator import fir_dec_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_MAX = DEF_LOG2_MAX,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
)(
  input logic CLK,
  input logic RST,
  fir_dec_if.slave bus
);
  localparam int DW = $clog2(LOG2_MAX+1);
  localparam int CW = $clog2(FIFO_DEPTH)+1;
  typedef logic signed [DATA_WIDTH-1:0] smp_t;
  logic [DW-1:0] dec_q, dec_d, dec_in;
  logic [LOG2_MAX-1:0] phase_q, phase_d, mask;
  logic take, last, keep, wr, rd, drop, full, empty, ovf_q, ovf_d;
  logic [CW-1:0] cnt;
  smp_t kept, head;
  assign dec_in = (bus.DEC_LOG2 > DW'(LOG2_MAX)) ? DW'(LOG2_MAX) : bus.DEC_LOG2;
  // A new exponent is only picked up between groups, so a group always completes at its start size.
  assign dec_d = (phase_q == '0) ? dec_in : dec_q;
  assign mask = ~({LOG2_MAX{1'b1}} << dec_d);
  assign take = bus.VIN && bus.EN;
  assign last = phase_q == mask;
  assign phase_d = !bus.EN ? '0 : take ? (last ? '0 : phase_q + 1'b1) : phase_q;
`ifdef FIR_DEC_AVG_EN
  typedef logic signed [DATA_WIDTH+LOG2_MAX-1:0] sum_t;
  sum_t acc_q, acc_d, sum;
  assign sum = acc_q + sum_t'(bus.DIN);
  // The group mean of DATA_WIDTH samples always fits back into DATA_WIDTH.
  assign kept = smp_t'(sum >>> dec_d);
  assign keep = take && last;
  assign acc_d = !bus.EN ? '0 : take ? (last ? '0 : sum) : acc_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) acc_q <= '0;
    else acc_q <= acc_d;
`else
  assign kept = bus.DIN;
  assign keep = take && phase_q == '0;
`endif
  assign rd = !empty && bus.READY;
  // A full FIFO still accepts the sample when the sink frees a slot in the same cycle.
  assign wr = keep && (!full || rd);
  assign drop = keep && full && !rd;
  assign ovf_d = drop || (ovf_q && !bus.CLR_OVF);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      phase_q <= '0;
      dec_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dec_q <= dec_d;
      ovf_q <= ovf_d;
    end
  fir_dec_fifo #(.DEPTH(FIFO_DEPTH), .T(smp_t)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .wr_i(wr),
    .rd_i(rd),
    .din_i(kept),
    .full_o(full),
    .empty_o(empty),
    .count_o(cnt),
    .head_o(head)
  );
  assign bus.DOUT = head;
  assign bus.VOUT = !empty;
  assign bus.COUNT = cnt;
  assign bus.OVF = ovf_q;
endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: directed-vector bench for fir_decimator.
module tb_fir_decimator;
  import fir_dec_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int got[$];
  fir_dec_if bus();
  fir_decimator dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.VOUT && bus.READY) got.push_back(int'(bus.DOUT));
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input int v);
    bus.DIN = sample_t'(v);
    bus.VIN = 1'b1;
    cyc();
  endtask
  task automatic check_q(input string tag, input int e[$]);
    chk({tag, "_n"}, got.size(), e.size());
    foreach (e[i]) chk($sformatf("%s_%0d", tag, i), i < got.size() ? got[i] : -99999, e[i]);
  endtask
  initial begin
    bus.DIN = '0;
    bus.VIN = 1'b0;
    bus.EN = 1'b1;
    bus.DEC_LOG2 = '0;
    bus.READY = 1'b1;
    bus.CLR_OVF = 1'b0;
    cyc(2);
    chk("rst_dout", int'(bus.DOUT), 0);
    chk("rst_vout", int'(bus.VOUT), 0);
    chk("rst_count", int'(bus.COUNT), 0);
    chk("rst_ovf", int'(bus.OVF), 0);
    rst = 1'b0;
    cyc();
    for (int i = 1; i <= 10; i++) begin
      send(i);
      chk($sformatf("t1_vout%0d", i), int'(bus.VOUT), 1);
      chk($sformatf("t1_dout%0d", i), int'(bus.DOUT), i);
    end
    bus.VIN = 1'b0;
    cyc();
    chk("t1_vout_end", int'(bus.VOUT), 0);
    chk("t1_ovf", int'(bus.OVF), 0);
    got.delete();
    bus.DEC_LOG2 = 2;
    for (int i = 0; i < 16; i++) send(i);
    bus.VIN = 1'b0;
    cyc(3);
`ifdef FIR_DEC_AVG_EN
    check_q("t2", '{1, 5, 9, 13});
`else
    check_q("t2", '{0, 4, 8, 12});
`endif
    bus.DEC_LOG2 = 0;
    bus.READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(21 + i);
      if (i == 7) begin
        chk("t3_count8", int'(bus.COUNT), 8);
        chk("t3_ovf8", int'(bus.OVF), 0);
      end
      if (i == 8) chk("t3_ovf9", int'(bus.OVF), 1);
    end
    bus.VIN = 1'b0;
    chk("t3_count", int'(bus.COUNT), 8);
    chk("t3_head", int'(bus.DOUT), 21);
    bus.READY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_drain%0d", k), int'(bus.DOUT), 21 + k);
      cyc();
    end
    chk("t3_empty", int'(bus.VOUT), 0);
    chk("t3_ovf_sticky", int'(bus.OVF), 1);
    bus.CLR_OVF = 1'b1;
    cyc();
    bus.CLR_OVF = 1'b0;
    chk("t3_ovf_clr", int'(bus.OVF), 0);
    bus.READY = 1'b0;
    for (int i = 41; i <= 48; i++) send(i);
    chk("t4_full", int'(bus.COUNT), 8);
    bus.READY = 1'b1;
    send(49);
    bus.VIN = 1'b0;
    chk("t4_count", int'(bus.COUNT), 8);
    chk("t4_ovf", int'(bus.OVF), 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4_drain%0d", k), int'(bus.DOUT), 42 + k);
      cyc();
    end
    chk("t4_empty", int'(bus.VOUT), 0);
    got.delete();
    bus.DEC_LOG2 = 2;
    send(60);
    bus.DEC_LOG2 = 1;
    for (int i = 61; i <= 69; i++) send(i);
    bus.VIN = 1'b0;
    cyc(3);
`ifdef FIR_DEC_AVG_EN
    check_q("t5a", '{61, 64, 66, 68});
`else
    check_q("t5a", '{60, 64, 66, 68});
`endif
    got.delete();
    bus.DEC_LOG2 = 7;
    for (int i = 100; i < 132; i++) send(i);
    bus.VIN = 1'b0;
    cyc(3);
`ifdef FIR_DEC_AVG_EN
    check_q("t5b", '{107, 123});
`else
    check_q("t5b", '{100, 116});
`endif
    bus.READY = 1'b0;
    bus.DEC_LOG2 = 0;
    for (int i = 150; i < 154; i++) send(i);
    bus.DEC_LOG2 = 2;
    send(154);
    send(155);
    bus.VIN = 1'b0;
`ifdef FIR_DEC_AVG_EN
    chk("t6_pre", int'(bus.COUNT), 4);
`else
    chk("t6_pre", int'(bus.COUNT), 5);
`endif
    #2 rst = 1'b1;
    #1;
    chk("t6_vout", int'(bus.VOUT), 0);
    chk("t6_count", int'(bus.COUNT), 0);
    cyc();
    rst = 1'b0;
    got.delete();
    bus.READY = 1'b1;
    for (int i = 200; i < 205; i++) send(i);
    bus.VIN = 1'b0;
    cyc(3);
`ifdef FIR_DEC_AVG_EN
    check_q("t6", '{201});
`else
    check_q("t6", '{200, 204});
`endif
    got.delete();
    bus.EN = 1'b0;
    send(77);
    bus.VIN = 1'b0;
    bus.EN = 1'b1;
    cyc();
    chk("t7_en_off", int'(bus.VOUT), 0);
    bus.DEC_LOG2 = 1;
    send(-3);
    send(-4);
    bus.VIN = 1'b0;
    cyc(2);
`ifdef FIR_DEC_AVG_EN
    check_q("t7", '{-4});
`else
    check_q("t7", '{-3});
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
